// File: rtl/rr_arbiter.sv
// Round-robin arbiter with transfer-level locking: a requester keeps the grant
// until its last beat is accepted, then the pointer moves past it.
module rr_arbiter #(
  parameter int unsigned COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [COUNT-1:0] req,
  input  logic [COUNT-1:0] req_last,
  output logic [COUNT-1:0] req_ready,
  output logic [COUNT-1:0] grant,
  output logic [3:0]       grant_idx,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int unsigned PtrW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned SumW = PtrW + 1;
  localparam logic [SumW-1:0]  CountS  = SumW'(COUNT);
  localparam logic [PtrW-1:0]  LastIdx = PtrW'(COUNT - 1);
  localparam logic [COUNT-1:0] OneHot0 = COUNT'(1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [COUNT-1:0] grant_q, grant_d;
  logic [3:0]       grant_idx_q, grant_idx_d;

  logic [PtrW-1:0]  cur_idx;
  logic [PtrW-1:0]  pick_idx;
  logic             pick_found;
  logic [SumW-1:0]  cand_sum;
  logic [PtrW-1:0]  cand;
  logic             beat_done;

  assign cur_idx = grant_idx_q[PtrW-1:0];

  // Scan ptr, ptr+1, ... modulo COUNT; the sum stays below 2*COUNT so one
  // conditional subtraction is enough to wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int unsigned off = 0; off < COUNT; off++) begin
      cand_sum = SumW'(ptr_q) + SumW'(off);
      if (cand_sum >= CountS) begin
        cand_sum = cand_sum - CountS;
      end
      cand = cand_sum[PtrW-1:0];
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign out_valid = (state_q == StBusy) & req[cur_idx];
  assign out_last  = (state_q == StBusy) & req_last[cur_idx];
  assign req_ready = grant_q & {COUNT{out_ready}};
  assign beat_done = out_valid & out_ready & out_last;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d     = StBusy;
          grant_d     = OneHot0 << pick_idx;
          grant_idx_d = 4'(pick_idx);
        end
      end
      StBusy: begin
        // Grant is held across idle beats and backpressure; only a last beat frees it.
        if (beat_done) begin
          state_d     = StIdle;
          ptr_d       = (cur_idx == LastIdx) ? '0 : cur_idx + PtrW'(1);
          grant_d     = '0;
          grant_idx_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (COUNT=4): directed vector table for the named scenarios,
// then random traffic compared against a transfer-level reference model.
module tb_rr_arbiter;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic [N-1:0] grant;
  logic [3:0]   grant_idx;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  // Reference state: who owns the output (if anyone) and where the next scan starts.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] lst;
    logic       rdy;
    logic [3:0] g;
    logic [3:0] idx;
    logic       v;
    logic       l;
    logic [3:0] ry;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter #(.COUNT(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] lst,
                     input logic rdy, input logic [3:0] g, input logic [3:0] idx,
                     input logic v, input logic l, input logic [3:0] ry);
    vec_t t;
    t.rst = rst; t.rq = rq; t.lst = lst; t.rdy = rdy;
    t.g = g; t.idx = idx; t.v = v; t.l = l; t.ry = ry;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int cyc, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                       input logic rdy);
    reset     = r;
    req       = rq;
    req_last  = lst;
    out_ready = rdy;
  endtask

  task automatic check_all(input int cyc, input logic [3:0] g, input logic [3:0] idx,
                           input logic v, input logic l, input logic [3:0] ry);
    check("grant", cyc, 16'(grant), 16'(g));
    check("grant_idx", cyc, 16'(grant_idx), 16'(idx));
    check("out_valid", cyc, 16'(out_valid), 16'(v));
    check("out_last", cyc, 16'(out_last), 16'(l));
    check("req_ready", cyc, 16'(req_ready), 16'(ry));
  endtask

  // Advance the reference by one clock edge using the inputs currently applied.
  task automatic model_step;
    bit found;
    if (reset) begin
      m_busy = 1'b0; m_ptr = 0; m_owner = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1'b1;
          m_owner = (m_ptr + k) % N;
        end
      end
      m_busy = found;
    end else if (req[m_owner] && out_ready && req_last[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end
  endtask

  task automatic advance;
    model_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] eg;
    logic [3:0] ei;
    logic       ev;
    logic       el;
    logic [3:0] er;

    // Reset, single requester, ptr advance
    add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 1, 0, 4'b0001);
    add(1, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0, 4'b0001);
    add(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0, 4'b0001);
    add(0, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0, 4'b0001);
    add(0, 4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 1, 4'b0001);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0011, 4'b0010, 1, 4'b0010, 1, 1, 1, 4'b0010);
    // Fairness: all requesting, every beat last
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 1, 4'b0001);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 1, 4'b0010);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0100, 2, 1, 1, 4'b0100);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 1, 1, 4'b1000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 1, 4'b0001);
    // Backpressure, dropped request, foreign requests
    add(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 0, 4'b0000);
    add(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 0, 4'b0000);
    add(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 0, 4'b0000);
    add(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 0, 4'b0010);
    add(0, 4'b0000, 4'b0010, 1, 4'b0010, 1, 0, 1, 4'b0010);
    add(0, 4'b1101, 4'b1101, 1, 4'b0010, 1, 0, 0, 4'b0010);
    add(0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1, 4'b0010);
    // Wrap from ptr=3 to index 0
    add(0, 4'b0100, 4'b0100, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0100, 4'b0100, 1, 4'b0100, 2, 1, 1, 4'b0100);
    add(0, 4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0011, 4'b0001, 1, 4'b0001, 0, 1, 1, 4'b0001);
    // Reset in the middle of a transfer
    add(0, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1000, 4'b0000, 1, 4'b1000, 3, 1, 0, 4'b1000);
    add(1, 4'b1001, 4'b0000, 1, 4'b1000, 3, 1, 0, 4'b1000);
    add(0, 4'b1001, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 1, 0, 4'b0001);
    // Last beat held off by out_ready, then released
    add(0, 4'b0001, 4'b0001, 0, 4'b0001, 0, 1, 1, 4'b0000);
    add(0, 4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 1, 4'b0001);
    add(0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 0, 0, 4'b0010);

    drive(1'b1, 4'b0000, 4'b0000, 1'b0);
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rq, vecs[i].lst, vecs[i].rdy);
      @(negedge clock);
      check_all(i, vecs[i].g, vecs[i].idx, vecs[i].v, vecs[i].l, vecs[i].ry);
      advance();
    end

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(31) == 0), 4'($urandom_range(15)), 4'($urandom_range(15)),
            ($urandom_range(3) != 0));
      @(negedge clock);
      eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
      ei = m_busy ? 4'(m_owner) : 4'd0;
      ev = m_busy && req[m_owner];
      el = m_busy && req_last[m_owner];
      er = out_ready ? eg : 4'b0000;
      check_all(1000 + i, eg, ei, ev, el, er);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The module SHALL have parameter COUNT, default 4, giving the number of requesters; legal range is 2..16.
REQ-002 The module SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clock.
REQ-004 The module SHALL have port req, input, COUNT bits, where req[i]=1 means requester i has a valid beat.
REQ-005 The module SHALL have port req_last, input, COUNT bits, where req_last[i] marks requester i's current beat as the final beat of its transfer.
REQ-006 The module SHALL have port req_ready, output, COUNT bits, where req_ready[i]=1 means requester i's beat is accepted this cycle.
REQ-007 The module SHALL have port grant, output, COUNT bits, registered, one-hot or zero; it directly drives a downstream one-hot-select data mux.
REQ-008 The module SHALL have port grant_idx, output, 4 bits, registered, giving the binary index of the set grant bit, or 0 when grant=0.
REQ-009 The module SHALL have port out_valid, output, 1 bit, indicating a beat is presented downstream.
REQ-010 The module SHALL have port out_last, output, 1 bit, the last flag of the presented beat.
REQ-011 The module SHALL have port out_ready, input, 1 bit, the downstream accept.

Function
REQ-012 The module SHALL implement a two-state machine: IDLE (grant=0) and BUSY (grant one-hot).
REQ-013 In IDLE with req!=0, the module SHALL select the first index i with req[i]=1, scanning ptr, ptr+1, ... modulo COUNT, then load grant=1<<i and grant_idx=i and enter BUSY on the next edge (1-cycle arbitration latency).
REQ-014 In IDLE with req=0, the module SHALL stay in IDLE with grant unchanged at 0.
REQ-015 The module SHALL drive out_valid = (state==BUSY) & req[grant_idx], combinationally.
REQ-016 The module SHALL drive out_last = (state==BUSY) & req_last[grant_idx], combinationally.
REQ-017 The module SHALL drive req_ready = grant masked by out_ready, combinationally; it SHALL be all-zero in IDLE.
REQ-018 A beat SHALL transfer in any cycle where out_valid & out_ready.
REQ-019 When a transfer has out_last=1, the module SHALL set ptr=(grant_idx+1) mod COUNT, clear grant and grant_idx to 0, and return to IDLE, giving one bubble cycle between transfers.
REQ-020 In BUSY, grant SHALL be locked until a last beat transfers; deassertion of req[grant_idx] SHALL only lower out_valid and SHALL NOT release the grant.
REQ-021 Requests from non-granted requesters in BUSY SHALL be ignored; their req_ready SHALL stay 0.
REQ-022 With out_ready=0, the module SHALL hold grant, grant_idx and ptr unchanged.
REQ-023 ptr SHALL be clog2(COUNT) bits wide, zero-extended to 4 bits for grant_idx, and SHALL wrap from COUNT-1 to 0.
REQ-024 grant SHALL never have more than one bit set.

Reset
REQ-025 On reset=1 at a clock edge, the module SHALL set state=IDLE, grant=0, grant_idx=0 and ptr=0, overriding all other events in that cycle.
REQ-026 The outputs out_valid, out_last and req_ready SHALL be 0 in the cycle after reset.
REQ-027 Reset during BUSY SHALL abandon the transfer with no completion; arbitration restarts from ptr=0.

Verification (COUNT=4)
REQ-028 Reset test: assert reset for 2 cycles with req=1111 -> grant=0000, grant_idx=0, out_valid=0 throughout; grant=0001 one cycle after reset drops.
REQ-029 Single-requester test: req=0001, out_ready=1, req_last high on the 3rd beat -> grant=0001 from cycle 1; 3 transfers with req_ready[0]=1; grant=0000 and ptr=1 afterwards.
REQ-030 Fairness test: req=1111 held, every beat last, out_ready=1 -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-031 Backpressure test: granted 0010 with out_ready=0 for 3 cycles -> req_ready=0000, grant stays 0010; first beat transfers when out_ready=1.
REQ-032 Wrap test: after a 0100 transfer completes (ptr=3), req=0011 -> grant=0001, grant_idx=0.
REQ-033 Mid-transfer reset test: reset pulsed while granted 1000 with last not yet sent -> grant=0000 next cycle; with req=1001, next grant=0001.
